// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings and writeback state type.
// Constants only; no timing or flow-control behaviour.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {
        WB_IDLE,
        WB_WAIT_LOAD
    } wb_state_t;

endpackage

// File: rtl/writeback_if.sv
// Execute-to-writeback handshake, load response and register-file write port.
// master drives instructions and memory data; slave is the writeback stage.
interface writeback_if #(
    parameter int WORD_SIZE = 32,
    parameter int CNT_WIDTH = 32
);
    logic                 ex_valid;
    logic                 ex_ready;
    logic [4:0]           ex_rd;
    logic                 ex_is_write;
    logic                 ex_is_mem_read;
    logic [2:0]           ex_funct3;
    logic [WORD_SIZE-1:0] ex_result;
    logic                 mem_rvalid;
    logic [WORD_SIZE-1:0] mem_rdata;
    logic                 write_enable;
    logic [4:0]           write_addr;
    logic [WORD_SIZE-1:0] write_data;
    logic                 load_error;
    logic [CNT_WIDTH-1:0] retired_count;

    modport master (
        output ex_valid, ex_rd, ex_is_write, ex_is_mem_read, ex_funct3, ex_result,
        output mem_rvalid, mem_rdata,
        input  ex_ready, write_enable, write_addr, write_data, load_error, retired_count
    );

    modport slave (
        input  ex_valid, ex_rd, ex_is_write, ex_is_mem_read, ex_funct3, ex_result,
        input  mem_rvalid, mem_rdata,
        output ex_ready, write_enable, write_addr, write_data, load_error, retired_count
    );
endinterface

// File: rtl/load_align.sv
// Load data extract/extend plus illegal-funct3 and misalignment detection.
// Purely combinational, zero latency, no flow control.
module load_align
    import riscv_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic [2:0]           funct3,
    input  logic [1:0]           addr,
    input  logic [WORD_SIZE-1:0] rdata,
    output logic [WORD_SIZE-1:0] data,
    output logic                 illegal,
    output logic                 misaligned
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = 8'h00;
        half_sel   = addr[1] ? rdata[31:16] : rdata[15:0];
        data       = '0;
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        case (funct3)
            F3_LB:   data = {{(WORD_SIZE-8){byte_sel[7]}}, byte_sel};
            F3_LH: begin
                data       = {{(WORD_SIZE-16){half_sel[15]}}, half_sel};
                misaligned = addr[0];
            end
            F3_LW: begin
                data       = rdata;
                misaligned = (addr != 2'd0);
            end
            F3_LBU:  data = {{(WORD_SIZE-8){1'b0}}, byte_sel};
            F3_LHU: begin
                data       = {{(WORD_SIZE-16){1'b0}}, half_sel};
                misaligned = addr[0];
            end
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/writeback.sv
// Retires ALU results and single outstanding loads into the register file; 1 cycle
// from accept (ALU) or mem_rvalid (load) to write; ex_ready low while a load is pending.
module writeback
    import riscv_pkg::*;
#(
    parameter int WORD_SIZE    = 32,
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_WIDTH    = 32
) (
    input  logic       clock,
    input  logic       reset,
    writeback_if.slave bus
);
    localparam logic [7:0] TMO_LAST = 8'(LOAD_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    wb_state_t            state;
    logic [4:0]           rd_q;
    logic [2:0]           f3_q;
    logic [1:0]           addr_q;
    logic                 err_q;
    logic [7:0]           tmo_cnt;
    logic                 we_q;
    logic [4:0]           wa_q;
    logic [WORD_SIZE-1:0] wd_q;
    logic                 le_q;
    logic [CNT_WIDTH-1:0] retired_q;

    logic [2:0]           sel_f3;
    logic [1:0]           sel_addr;
    logic [WORD_SIZE-1:0] fmt_data;
    logic                 fmt_illegal;
    logic                 fmt_misaligned;

    // One aligner serves both the capture-time checks and the response formatting.
    assign sel_f3   = (state == WB_IDLE) ? bus.ex_funct3     : f3_q;
    assign sel_addr = (state == WB_IDLE) ? bus.ex_result[1:0] : addr_q;

    load_align #(.WORD_SIZE(WORD_SIZE)) u_align (
        .funct3     (sel_f3),
        .addr       (sel_addr),
        .rdata      (bus.mem_rdata),
        .data       (fmt_data),
        .illegal    (fmt_illegal),
        .misaligned (fmt_misaligned)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= WB_IDLE;
            rd_q      <= '0;
            f3_q      <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            tmo_cnt   <= '0;
            we_q      <= 1'b0;
            wa_q      <= '0;
            wd_q      <= '0;
            le_q      <= 1'b0;
            retired_q <= '0;
        end else begin
            we_q <= 1'b0;
            wa_q <= '0;
            wd_q <= '0;
            le_q <= 1'b0;
            case (state)
                WB_IDLE: begin
                    if (bus.ex_valid) begin
                        if (bus.ex_is_mem_read) begin
                            rd_q    <= bus.ex_rd;
                            f3_q    <= bus.ex_funct3;
                            addr_q  <= bus.ex_result[1:0];
                            err_q   <= fmt_illegal | fmt_misaligned;
                            tmo_cnt <= '0;
                            state   <= WB_WAIT_LOAD;
                        end else begin
                            retired_q <= retired_q + CNT_ONE;
                            if (bus.ex_is_write && bus.ex_rd != 5'd0) begin
                                we_q <= 1'b1;
                                wa_q <= bus.ex_rd;
                                wd_q <= bus.ex_result;
                            end
                        end
                    end
                end
                WB_WAIT_LOAD: begin
                    // Data arriving on the expiry cycle takes priority over the timeout.
                    if (bus.mem_rvalid) begin
                        state <= WB_IDLE;
                        if (err_q) begin
                            le_q <= 1'b1;
                        end else begin
                            retired_q <= retired_q + CNT_ONE;
                            if (rd_q != 5'd0) begin
                                we_q <= 1'b1;
                                wa_q <= rd_q;
                                wd_q <= fmt_data;
                            end
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        le_q  <= 1'b1;
                        state <= WB_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

    assign bus.ex_ready      = (state == WB_IDLE);
    assign bus.write_enable  = we_q;
    assign bus.write_addr    = wa_q;
    assign bus.write_data    = wd_q;
    assign bus.load_error    = le_q;
    assign bus.retired_count = retired_q;
endmodule
